// File: rtl/hadamard_issue_if.sv
// Handshake and bus bundle between the Hadamard issue controller, its sample source,
// the 4-lane engine and the result sink. Lane k occupies bits [FW*(k+1)-1:FW*k].
interface hadamard_issue_if #(
    parameter int FW = 9
);
    logic            in_valid;
    logic            in_ready;
    logic [FW-1:0]   in_real;
    logic [FW-1:0]   in_imag;
    logic [FW-1:0]   in_tw_real;
    logic [FW-1:0]   in_tw_imag;
    logic            in_last;

    logic            eng_start;
    logic [4*FW-1:0] eng_in_real;
    logic [4*FW-1:0] eng_in_imag;
    logic [4*FW-1:0] eng_tw_real;
    logic [4*FW-1:0] eng_tw_imag;
    logic [4*FW-1:0] eng_out_real;
    logic [4*FW-1:0] eng_out_imag;

    logic            out_valid;
    logic            out_ready;
    logic [4*FW-1:0] out_real;
    logic [4*FW-1:0] out_imag;
    logic            out_last;

    logic            busy;
    logic            err_overflow;

    // Controller side.
    modport slave (
        input  in_valid, in_real, in_imag, in_tw_real, in_tw_imag, in_last,
        input  eng_out_real, eng_out_imag, out_ready,
        output in_ready, eng_start, eng_in_real, eng_in_imag, eng_tw_real, eng_tw_imag,
        output out_valid, out_real, out_imag, out_last, busy, err_overflow
    );

    // Environment side: sample source, engine and result sink.
    modport master (
        output in_valid, in_real, in_imag, in_tw_real, in_tw_imag, in_last,
        output eng_out_real, eng_out_imag, out_ready,
        input  in_ready, eng_start, eng_in_real, eng_in_imag, eng_tw_real, eng_tw_imag,
        input  out_valid, out_real, out_imag, out_last, busy, err_overflow
    );
endinterface

// File: rtl/hadamard_issue_ctrl.sv
// Groups serial complex samples into 4-lane issues for the Hadamard engine, tracks the
// engine's fixed latency and collects results into a credit-protected output FIFO.
module hadamard_issue_ctrl #(
    parameter int expWidth    = 4,
    parameter int sigWidth    = 4,
    parameter int formatWidth = 9,
    parameter int LATENCY     = 5,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    hadamard_issue_if.slave   bus
);
    localparam int FW    = formatWidth;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int SUM_W = $clog2(FIFO_DEPTH + LATENCY + 1);

    localparam logic [0:0] S_FILL  = 1'b0;
    localparam logic [0:0] S_ISSUE = 1'b1;

    if (1 + expWidth + sigWidth != formatWidth) begin : g_bad_format
        $error("formatWidth must equal 1 + expWidth + sigWidth");
    end
    if (FIFO_DEPTH < LATENCY + 1) begin : g_bad_depth
        $error("FIFO_DEPTH must be at least LATENCY + 1");
    end

    logic [0:0]         state;
    logic [1:0]         lane_cnt;
    logic               last_flag;
    logic [FW-1:0]      lane_re  [4];
    logic [FW-1:0]      lane_im  [4];
    logic [FW-1:0]      lane_twr [4];
    logic [FW-1:0]      lane_twi [4];

    logic [LATENCY-1:0] dl_valid;
    logic [LATENCY-1:0] dl_last;

    logic [4*FW-1:0]     fifo_re [FIFO_DEPTH];
    logic [4*FW-1:0]     fifo_im [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_last;
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    fifo_count;
    logic                err_q;

    logic               in_fire;
    logic               close_grp;
    logic [SUM_W-1:0]   credit_used;
    logic               credit_ok;
    logic               issue;
    logic               capture;
    logic               fifo_full;
    logic               pop;
    logic               push;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign in_fire     = bus.in_valid && (state == S_FILL);
    assign close_grp   = in_fire && ((lane_cnt == 2'd3) || bus.in_last);
    // Every group issued but not yet popped holds a FIFO slot, so the FIFO can never overflow.
    assign credit_used = SUM_W'(fifo_count) + SUM_W'($countones(dl_valid));
    assign credit_ok   = credit_used < SUM_W'(FIFO_DEPTH);
    assign issue       = (state == S_ISSUE) && credit_ok;
    assign capture     = dl_valid[LATENCY-1];
    assign fifo_full   = (fifo_count == CNT_W'(FIFO_DEPTH));
    assign pop         = bus.out_ready && (fifo_count != '0);
    assign push        = capture && (!fifo_full || pop);

    // NOTE: clocked blocks use non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_FILL;
            lane_cnt  <= '0;
            last_flag <= 1'b0;
        end else begin
            case (state)
                S_FILL: begin
                    if (in_fire) begin
                        lane_cnt <= lane_cnt + 2'd1;
                        if (close_grp) begin
                            last_flag <= bus.in_last;
                            state     <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (credit_ok) begin
                        lane_cnt <= '0;
                        state    <= S_FILL;
                    end
                end
                default: state <= S_FILL;
            endcase
        end
    end

    // The first sample of a group zeroes the other lanes, so an early in_last leaves them at SFP +0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 4; k++) begin
                lane_re[k]  <= '0;
                lane_im[k]  <= '0;
                lane_twr[k] <= '0;
                lane_twi[k] <= '0;
            end
        end else if (in_fire) begin
            for (int k = 0; k < 4; k++) begin
                if (lane_cnt == 2'(k)) begin
                    lane_re[k]  <= bus.in_real;
                    lane_im[k]  <= bus.in_imag;
                    lane_twr[k] <= bus.in_tw_real;
                    lane_twi[k] <= bus.in_tw_imag;
                end else if (lane_cnt == 2'd0) begin
                    lane_re[k]  <= '0;
                    lane_im[k]  <= '0;
                    lane_twr[k] <= '0;
                    lane_twi[k] <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dl_valid <= '0;
            dl_last  <= '0;
        end else begin
            dl_valid <= (dl_valid << 1) | LATENCY'(issue);
            dl_last  <= (dl_last << 1)  | LATENCY'(last_flag);
        end
    end

    // NOTE: the FIFO storage is reset because out_* read the head entry directly and must be 0 after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_re[i] <= '0;
                fifo_im[i] <= '0;
            end
            fifo_last  <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            err_q      <= 1'b0;
        end else begin
            if (push) begin
                fifo_re[wr_ptr]   <= bus.eng_out_real;
                fifo_im[wr_ptr]   <= bus.eng_out_imag;
                fifo_last[wr_ptr] <= dl_last[LATENCY-1];
                wr_ptr            <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            if (capture && !push) begin
                err_q <= 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    assign bus.in_ready     = (state == S_FILL);
    assign bus.eng_start    = issue;
    assign bus.eng_in_real  = {lane_re[3],  lane_re[2],  lane_re[1],  lane_re[0]};
    assign bus.eng_in_imag  = {lane_im[3],  lane_im[2],  lane_im[1],  lane_im[0]};
    assign bus.eng_tw_real  = {lane_twr[3], lane_twr[2], lane_twr[1], lane_twr[0]};
    assign bus.eng_tw_imag  = {lane_twi[3], lane_twi[2], lane_twi[1], lane_twi[0]};
    assign bus.out_valid    = (fifo_count != '0);
    assign bus.out_real     = fifo_re[rd_ptr];
    assign bus.out_imag     = fifo_im[rd_ptr];
    assign bus.out_last     = fifo_last[rd_ptr];
    assign bus.busy         = (state == S_ISSUE) || (lane_cnt != 2'd0) || (|dl_valid) || (fifo_count != '0);
    assign bus.err_overflow = err_q;

endmodule
